// File: rtl/kd_node_ce_if.sv
// Handshake and operand/result bundle between the kd-tree controller and one
// kd_node_ce compute element.
interface kd_node_ce_if #(
  parameter int DIM    = 3,
  parameter int DATA_W = 8
);
  localparam int AXIS_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int DIST_W = $clog2(DIM * (2**DATA_W - 1) + 1);
  localparam int CW     = DIM * DATA_W;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [AXIS_W-1:0] axis;
  logic              left_en;
  logic              right_en;
  logic              returned;
  logic [CW-1:0]     left;
  logic [CW-1:0]     parent;
  logic [CW-1:0]     right;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     new_left;
  logic [CW-1:0]     new_parent;
  logic [CW-1:0]     new_right;
  logic              stable;
  logic              left_switch;
  logic              parent_switch;
  logic              right_switch;
  logic              first_direction;
  logic              other_branch;
  logic              change_best;
  logic [DIST_W-1:0] best_dist;

  modport master (
    output in_valid, op, axis, left_en, right_en, returned, left, parent, right, out_ready,
    input  in_ready, out_valid, new_left, new_parent, new_right, stable, left_switch,
           parent_switch, right_switch, first_direction, other_branch, change_best, best_dist
  );

  modport slave (
    input  in_valid, op, axis, left_en, right_en, returned, left, parent, right, out_ready,
    output in_ready, out_valid, new_left, new_parent, new_right, stable, left_switch,
           parent_switch, right_switch, first_direction, other_branch, change_best, best_dist
  );
endinterface

// File: rtl/kd_node_ce.sv
// kd-tree node compute element: stable axis SORT of node/children and serial Manhattan QUERY step.
// Optional macro KD_CE_PARALLEL_DIST_EN computes both distances in a single ACC cycle.
module kd_node_ce #(
  parameter int DIM    = 3,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  kd_node_ce_if.slave  bus
);
  localparam int AXIS_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int DIST_W = $clog2(DIM * (2**DATA_W - 1) + 1);
  localparam int CW     = DIM * DATA_W;
  localparam logic [AXIS_W:0] DIM_L = (AXIS_W+1)'(DIM);

  typedef enum logic [2:0] {ST_IDLE, ST_SORT, ST_ACC, ST_EVAL, ST_DONE} state_t;

  state_t            state_r, state_s;
  logic              accept_s;
  logic [CW-1:0]     left_q_r, parent_q_r, right_q_r;
  logic [AXIS_W-1:0] axis_r;
  logic              left_en_r, right_en_r, returned_r;
  logic [DIST_W-1:0] acc_c_r, acc_b_r;
`ifndef KD_CE_PARALLEL_DIST_EN
  logic [AXIS_W-1:0] dim_r;
`endif

  logic              in_ready_r, out_valid_r;
  logic [CW-1:0]     new_left_r, new_parent_r, new_right_r;
  logic              stable_r, left_switch_r, parent_switch_r, right_switch_r;
  logic              first_direction_r, other_branch_r, change_best_r;
  logic [DIST_W-1:0] best_dist_r;

  function automatic logic [DATA_W-1:0] get_coord(input logic [CW-1:0] c, input int d);
    get_coord = c[d*DATA_W +: DATA_W];
  endfunction

  // Unsigned |a-b| as larger minus smaller; no sign bit is involved
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (a > b) abs_diff = a - b;
    else       abs_diff = b - a;
  endfunction

`ifdef KD_CE_PARALLEL_DIST_EN
  function automatic logic [DIST_W-1:0] sum_dist(input logic [CW-1:0] a, input logic [CW-1:0] b);
    sum_dist = {DIST_W{1'b0}};
    for (int d = 0; d < DIM; d++) begin
      sum_dist = sum_dist + DIST_W'(abs_diff(get_coord(a, d), get_coord(b, d)));
    end
  endfunction
`endif

  function automatic logic [CW-1:0] pick(input logic [1:0] src, input logic [CW-1:0] l,
                                         input logic [CW-1:0] p, input logic [CW-1:0] r);
    case (src)
      2'd0:    pick = l;
      2'd1:    pick = p;
      default: pick = r;
    endcase
  endfunction

  // Stable 3-slot bubble sort on {key, source}; each pass only runs when both its slots participate
  localparam int EW = DATA_W + 2;
  logic [EW-1:0] e0_s, e1_s, e2_s, a0_s, a1_s, b1_s;
  logic          swap1_s, swap2_s, swap3_s;
  logic [1:0]    src0_s, src1_s, src2_s;

  assign e0_s    = {get_coord(left_q_r,   int'(axis_r)), 2'd0};
  assign e1_s    = {get_coord(parent_q_r, int'(axis_r)), 2'd1};
  assign e2_s    = {get_coord(right_q_r,  int'(axis_r)), 2'd2};
  assign swap1_s = left_en_r && (e1_s[EW-1:2] < e0_s[EW-1:2]);
  assign a0_s    = swap1_s ? e1_s : e0_s;
  assign a1_s    = swap1_s ? e0_s : e1_s;
  assign swap2_s = right_en_r && (e2_s[EW-1:2] < a1_s[EW-1:2]);
  assign b1_s    = swap2_s ? e2_s : a1_s;
  assign src2_s  = swap2_s ? a1_s[1:0] : e2_s[1:0];
  assign swap3_s = left_en_r && right_en_r && (b1_s[EW-1:2] < a0_s[EW-1:2]);
  assign src0_s  = swap3_s ? b1_s[1:0] : a0_s[1:0];
  assign src1_s  = swap3_s ? a0_s[1:0] : b1_s[1:0];

  // QUERY evaluation from the finished accumulators
  logic              change_best_s;
  logic [DIST_W-1:0] best_s, axis_dist_s;
  logic [DATA_W-1:0] pt_axis_s, nd_axis_s;

  assign change_best_s = acc_c_r < acc_b_r;
  assign best_s        = change_best_s ? acc_c_r : acc_b_r;
  assign pt_axis_s     = get_coord(parent_q_r, int'(axis_r));
  assign nd_axis_s     = get_coord(left_q_r,   int'(axis_r));
  assign axis_dist_s   = DIST_W'(abs_diff(pt_axis_s, nd_axis_s));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Next-state and accept decode
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          case (bus.op)
            2'd0:    state_s = ST_SORT;
            2'd1:    state_s = ST_ACC;
            default: state_s = ST_DONE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SORT: state_s = ST_DONE;
      ST_ACC: begin
`ifdef KD_CE_PARALLEL_DIST_EN
        state_s = ST_EVAL;
`else
        if (dim_r == AXIS_W'(DIM - 1)) state_s = ST_EVAL;
        else                           state_s = ST_ACC;
`endif
      end
      ST_EVAL: state_s = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) state_s = ST_IDLE;
        else               state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture on accept; out-of-range axis folds to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q_r   <= {CW{1'b0}};
      parent_q_r <= {CW{1'b0}};
      right_q_r  <= {CW{1'b0}};
      axis_r     <= {AXIS_W{1'b0}};
      left_en_r  <= 1'b0;
      right_en_r <= 1'b0;
      returned_r <= 1'b0;
    end else if (accept_s) begin
      left_q_r   <= bus.left;
      parent_q_r <= bus.parent;
      right_q_r  <= bus.right;
      axis_r     <= ({1'b0, bus.axis} < DIM_L) ? bus.axis : {AXIS_W{1'b0}};
      left_en_r  <= bus.left_en;
      right_en_r <= bus.right_en;
      returned_r <= bus.returned;
    end
  end

  // Distance accumulators (and dimension counter in the serial build)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_c_r <= {DIST_W{1'b0}};
      acc_b_r <= {DIST_W{1'b0}};
`ifndef KD_CE_PARALLEL_DIST_EN
      dim_r   <= {AXIS_W{1'b0}};
`endif
    end else if (accept_s) begin
      acc_c_r <= {DIST_W{1'b0}};
      acc_b_r <= {DIST_W{1'b0}};
`ifndef KD_CE_PARALLEL_DIST_EN
      dim_r   <= {AXIS_W{1'b0}};
`endif
    end else if (state_r == ST_ACC) begin
`ifdef KD_CE_PARALLEL_DIST_EN
      acc_c_r <= sum_dist(parent_q_r, left_q_r);
      acc_b_r <= sum_dist(parent_q_r, right_q_r);
`else
      acc_c_r <= acc_c_r + DIST_W'(abs_diff(get_coord(parent_q_r, int'(dim_r)), get_coord(left_q_r, int'(dim_r))));
      acc_b_r <= acc_b_r + DIST_W'(abs_diff(get_coord(parent_q_r, int'(dim_r)), get_coord(right_q_r, int'(dim_r))));
      dim_r   <= dim_r + AXIS_W'(1);
`endif
    end
  end

  // Output registers: loaded on the way into DONE, held while out_ready is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r        <= 1'b1;
      out_valid_r       <= 1'b0;
      new_left_r        <= {CW{1'b0}};
      new_parent_r      <= {CW{1'b0}};
      new_right_r       <= {CW{1'b0}};
      stable_r          <= 1'b0;
      left_switch_r     <= 1'b0;
      parent_switch_r   <= 1'b0;
      right_switch_r    <= 1'b0;
      first_direction_r <= 1'b0;
      other_branch_r    <= 1'b0;
      change_best_r     <= 1'b0;
      best_dist_r       <= {DIST_W{1'b0}};
    end else begin
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
      if (accept_s && bus.op[1]) begin
        new_left_r        <= bus.left;
        new_parent_r      <= bus.parent;
        new_right_r       <= bus.right;
        stable_r          <= 1'b1;
        left_switch_r     <= 1'b0;
        parent_switch_r   <= 1'b0;
        right_switch_r    <= 1'b0;
        first_direction_r <= 1'b0;
        other_branch_r    <= 1'b0;
        change_best_r     <= 1'b0;
        best_dist_r       <= {DIST_W{1'b0}};
      end else if (state_r == ST_SORT) begin
        new_left_r        <= pick(src0_s, left_q_r, parent_q_r, right_q_r);
        new_parent_r      <= pick(src1_s, left_q_r, parent_q_r, right_q_r);
        new_right_r       <= pick(src2_s, left_q_r, parent_q_r, right_q_r);
        left_switch_r     <= (src0_s != 2'd0);
        parent_switch_r   <= (src1_s != 2'd1);
        right_switch_r    <= (src2_s != 2'd2);
        stable_r          <= (src0_s == 2'd0) && (src1_s == 2'd1) && (src2_s == 2'd2);
        first_direction_r <= 1'b0;
        other_branch_r    <= 1'b0;
        change_best_r     <= 1'b0;
        best_dist_r       <= {DIST_W{1'b0}};
      end else if (state_r == ST_EVAL) begin
        new_left_r        <= {CW{1'b0}};
        new_parent_r      <= change_best_s ? left_q_r : right_q_r;
        new_right_r       <= {CW{1'b0}};
        stable_r          <= 1'b0;
        left_switch_r     <= 1'b0;
        parent_switch_r   <= 1'b0;
        right_switch_r    <= 1'b0;
        change_best_r     <= change_best_s;
        best_dist_r       <= best_s;
        first_direction_r <= (pt_axis_s < nd_axis_s);
        other_branch_r    <= returned_r && (best_s > axis_dist_s);
      end
    end
  end

  assign bus.in_ready        = in_ready_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.new_left        = new_left_r;
  assign bus.new_parent      = new_parent_r;
  assign bus.new_right       = new_right_r;
  assign bus.stable          = stable_r;
  assign bus.left_switch     = left_switch_r;
  assign bus.parent_switch   = parent_switch_r;
  assign bus.right_switch    = right_switch_r;
  assign bus.first_direction = first_direction_r;
  assign bus.other_branch    = other_branch_r;
  assign bus.change_best     = change_best_r;
  assign bus.best_dist       = best_dist_r;
endmodule

// File: tb/tb_kd_node_ce.sv
// Scoreboard bench for kd_node_ce (DIM=3, DATA_W=8): expected results queued at accept, checked at out_valid.
module tb_kd_node_ce;
  localparam int DIM    = 3;
  localparam int DATA_W = 8;

  typedef struct {
    logic [23:0] nl, np, nr;
    logic        st, ls, ps, rs, fd, ob, cb;
    logic [9:0]  bd;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  kd_node_ce_if #(.DIM(DIM), .DATA_W(DATA_W)) bus ();
  kd_node_ce #(.DIM(DIM), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [23:0] mk(input int x, input int y, input int z);
    mk = {z[7:0], y[7:0], x[7:0]};
  endfunction

  function automatic int crd(input logic [23:0] c, input int d);
    crd = int'(c[d*8 +: 8]);
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [1:0] ax, input logic le,
                                 input logic re, input logic ret, input logic [23:0] l,
                                 input logic [23:0] p, input logic [23:0] r);
    exp_t e;
    logic [23:0] c[3];
    logic [23:0] o[3];
    logic sw[3];
    int slot[3];
    int ord[3];
    int n, a, tmp, sc, sbd, ad;
    c[0] = l; c[1] = p; c[2] = r;
    a = (int'(ax) >= DIM) ? 0 : int'(ax);
    e.nl = 24'd0; e.np = 24'd0; e.nr = 24'd0; e.bd = 10'd0;
    e.st = 1'b0; e.ls = 1'b0; e.ps = 1'b0; e.rs = 1'b0;
    e.fd = 1'b0; e.ob = 1'b0; e.cb = 1'b0;
    if (op == 2'd0) begin
      n = 0;
      for (int s = 0; s < 3; s++) begin
        o[s] = c[s]; sw[s] = 1'b0;
        if (s == 1 || (s == 0 && le) || (s == 2 && re)) begin
          slot[n] = s; ord[n] = s; n++;
        end
      end
      for (int i = 1; i < n; i++) begin
        for (int j = i; j > 0; j--) begin
          if (crd(c[ord[j]], a) < crd(c[ord[j-1]], a)) begin
            tmp = ord[j]; ord[j] = ord[j-1]; ord[j-1] = tmp;
          end
        end
      end
      for (int i = 0; i < n; i++) begin
        o[slot[i]]  = c[ord[i]];
        sw[slot[i]] = (ord[i] != slot[i]);
      end
      e.nl = o[0]; e.np = o[1]; e.nr = o[2];
      e.ls = sw[0]; e.ps = sw[1]; e.rs = sw[2];
      e.st = !(sw[0] || sw[1] || sw[2]);
      e.lat = 2;
    end else if (op == 2'd1) begin
      sc = 0; sbd = 0;
      for (int d = 0; d < DIM; d++) begin
        sc  += (crd(p, d) > crd(l, d)) ? crd(p, d) - crd(l, d) : crd(l, d) - crd(p, d);
        sbd += (crd(p, d) > crd(r, d)) ? crd(p, d) - crd(r, d) : crd(r, d) - crd(p, d);
      end
      ad   = (crd(p, a) > crd(l, a)) ? crd(p, a) - crd(l, a) : crd(l, a) - crd(p, a);
      e.cb = (sc < sbd);
      e.np = e.cb ? l : r;
      e.bd = e.cb ? sc[9:0] : sbd[9:0];
      e.fd = crd(p, a) < crd(l, a);
      e.ob = ret && (int'(e.bd) > ad);
`ifdef KD_CE_PARALLEL_DIST_EN
      e.lat = 3;
`else
      e.lat = DIM + 2;
`endif
    end else begin
      e.nl = l; e.np = p; e.nr = r; e.st = 1'b1;
      e.lat = 1;
    end
    return e;
  endfunction

  task automatic cmp_out(input exp_t g, input string pre);
    check_eq({pre, "new_left"},        32'(bus.new_left),      32'(g.nl));
    check_eq({pre, "new_parent"},      32'(bus.new_parent),    32'(g.np));
    check_eq({pre, "new_right"},       32'(bus.new_right),     32'(g.nr));
    check_eq({pre, "stable"},          32'(bus.stable),        32'(g.st));
    check_eq({pre, "left_switch"},     32'(bus.left_switch),   32'(g.ls));
    check_eq({pre, "parent_switch"},   32'(bus.parent_switch), 32'(g.ps));
    check_eq({pre, "right_switch"},    32'(bus.right_switch),  32'(g.rs));
    check_eq({pre, "first_direction"}, 32'(bus.first_direction), 32'(g.fd));
    check_eq({pre, "other_branch"},    32'(bus.other_branch),  32'(g.ob));
    check_eq({pre, "change_best"},     32'(bus.change_best),   32'(g.cb));
    check_eq({pre, "best_dist"},       32'(bus.best_dist),     32'(g.bd));
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] ax, input logic le, input logic re,
                       input logic ret, input logic [23:0] l, input logic [23:0] p, input logic [23:0] r);
    bus.in_valid = 1'b1; bus.op = op; bus.axis = ax;
    bus.left_en = le; bus.right_en = re; bus.returned = ret;
    bus.left = l; bus.parent = p; bus.right = r;
  endtask

  task automatic scramble();
    bus.op = 2'($urandom()); bus.axis = 2'($urandom());
    bus.left_en = 1'($urandom()); bus.right_en = 1'($urandom()); bus.returned = 1'($urandom());
    bus.left = 24'($urandom()); bus.parent = 24'($urandom()); bus.right = 24'($urandom());
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] ax, input logic le, input logic re,
                        input logic ret, input logic [23:0] l, input logic [23:0] p,
                        input logic [23:0] r, input int hold);
    exp_t g;
    int   n;
    @(negedge clk);
    check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
    drive(op, ax, le, re, ret, l, p, r);
    sb.push_back(model(op, ax, le, re, ret, l, p, r));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("out_valid", 32'(bus.out_valid), 32'd1);
    g = sb.pop_front();
    check_eq("latency", 32'(n), 32'(g.lat));
    cmp_out(g, "");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      scramble();
      @(posedge clk); #1;
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
      cmp_out(g, "hold_");
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("release_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 2'd0; bus.axis = 2'd0; bus.left_en = 1'b0; bus.right_en = 1'b0; bus.returned = 1'b0;
    bus.left = 24'd0; bus.parent = 24'd0; bus.right = 24'd0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    cmp_out(model(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0), "rst_");
    @(negedge clk) rst = 1'b1;

    // Directed cases
    run_op(2'd0, 2'd0, 1'b1, 1'b1, 1'b0, mk(50, 1, 2), mk(30, 3, 4), mk(10, 5, 6), 0);
    run_op(2'd0, 2'd0, 1'b1, 1'b0, 1'b0, mk(20, 9, 9), mk(20, 7, 7), mk(5, 1, 1), 0);
    run_op(2'd1, 2'd0, 1'b0, 1'b0, 1'b1, mk(12, 8, 10), mk(10, 10, 10), mk(0, 0, 0), 0);
    run_op(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, mk(255, 255, 255), mk(0, 0, 0), mk(1, 1, 1), 0);
    run_op(2'd2, 2'd1, 1'b1, 1'b1, 1'b1, mk(3, 4, 5), mk(6, 7, 8), mk(9, 10, 11), 0);
    run_op(2'd0, 2'd3, 1'b1, 1'b1, 1'b0, mk(9, 0, 0), mk(5, 0, 0), mk(5, 0, 0), 0);
    run_op(2'd1, 2'd2, 1'b0, 1'b0, 1'b1, mk(1, 2, 3), mk(1, 2, 3), mk(3, 2, 1), 0);

    // Backpressure with an intruding request
    run_op(2'd1, 2'd1, 1'b0, 1'b0, 1'b1, mk(40, 60, 80), mk(50, 50, 50), mk(90, 90, 90), 5);
    run_op(2'd3, 2'd0, 1'b0, 1'b0, 1'b0, mk(1, 1, 1), mk(2, 2, 2), mk(3, 3, 3), 0);

    // Randomised mix; odd iterations use a tiny coordinate range to force ties
    for (int i = 0; i < 24; i++) begin
      logic [23:0] l, p, r;
      if (i % 2 == 1) begin
        l = mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        p = mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        r = mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      end else begin
        l = 24'($urandom()); p = 24'($urandom()); r = 24'($urandom());
      end
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom()), 1'($urandom()),
             1'($urandom()), l, p, r, (i % 5 == 0) ? 2 : 0);
    end

    // Reset during the second ACC cycle of a QUERY
    @(negedge clk);
    drive(2'd1, 2'd0, 1'b0, 1'b0, 1'b1, mk(12, 8, 10), mk(10, 10, 10), mk(0, 0, 0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    cmp_out(model(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0), "midrst_");
    @(negedge clk) rst = 1'b1;
    run_op(2'd1, 2'd0, 1'b0, 1'b0, 1'b1, mk(12, 8, 10), mk(10, 10, 10), mk(0, 0, 0), 0);

    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kd_node_ce.md
Name: kd_node_ce

Overview:
- Parametrised, sequential successor to the kd-tree cluster compute element.
- Generalised to any dimension count, with a valid/ready handshake on both sides and registered outputs.
- Two operations:
  - SORT: stable axis-ordering of a node and its enabled children.
  - QUERY: nearest-centre step, using a true unsigned Manhattan distance accumulated one dimension per cycle.
- Sits in each kd-tree node slot, between the tree controller and the node/child centre registers.

Parameters:
DIM, 3, number of dimensions per centre (>=1)
DATA_W, 8, bits per coordinate (unsigned)
AXIS_W (localparam), max(1,$clog2(DIM)), axis index width
DIST_W (localparam), $clog2(DIM*(2**DATA_W-1)+1), Manhattan distance width (10 for defaults)
CW (localparam), DIM*DATA_W, packed centre width; coordinate d at bits [d*DATA_W +: DATA_W]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operation request
in_ready  out  1  high only in IDLE
op  in  2  0=SORT, 1=QUERY, 2/3=NOP
axis  in  AXIS_W  split axis; values >=DIM are treated as 0
left_en, right_en  in  1  SORT: child slot participates
returned  in  1  QUERY: search has returned from the first branch
left, parent, right  in  CW  SORT: three centres. QUERY: left=node centre, parent=point, right=current best
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  result consumed
new_left, new_parent, new_right  out  CW  results
stable, left_switch, parent_switch, right_switch  out  1  SORT status
first_direction, other_branch, change_best  out  1  QUERY status
best_dist  out  DIST_W  QUERY: distance of winning centre

Behaviour:
- Operands are latched into internal registers on accept (in_valid && in_ready). Inputs are don't-care afterwards.
- Reset value of every output is 0, except in_ready=1. Async reset at any time (mid-operation included) returns the FSM to IDLE and clears the counter and accumulators. The operation in flight is discarded.
- FSM states: IDLE, SORT, ACC, EVAL, DONE.
  - IDLE: accept op=0 -> SORT; op=1 -> ACC (dim counter=0); op=2/3 -> DONE with outputs = latched inputs, all flags 0, stable=1.
  - SORT: one cycle, -> DONE.
  - ACC: one dimension d per cycle. acc_c += |point[d]-left[d]| and acc_b += |point[d]-right[d]|. The absolute difference is computed as a width-correct unsigned difference (larger minus smaller), never by sign bit. After d=DIM-1 -> EVAL.
  - EVAL: one cycle, -> DONE.
  - DONE: out_valid=1; all outputs stable while out_ready=0; -> IDLE on out_ready.
- Latency from accept cycle T:
  - SORT/NOP: out_valid at T+2 and T+1 respectively.
  - QUERY: out_valid at T+DIM+2.
  - Throughput: one operation per (latency+1) cycles minimum, because in_ready is low outside IDLE.
- SORT:
  - Participants are parent always, left if left_en, right if right_en.
  - Participants are reordered ascending by the coordinate at axis into slot order left, parent, right, skipping disabled slots.
  - Ties keep original relative order.
  - Disabled slots pass through unchanged.
  - x_switch=1 iff slot x now holds a different source slot. stable = no switch.
  - QUERY flags are 0.
- QUERY (EVAL):
  - change_best = acc_c < acc_b (strict; a tie keeps best).
  - new_parent = change_best ? left : right; new_left = new_right = 0.
  - best_dist = min(acc_c, acc_b).
  - axis_dist = |point[axis]-left[axis]|.
  - first_direction = point[axis] < left[axis] (1 = go left).
  - other_branch = returned && (best_dist > axis_dist).
  - SORT flags are 0.
- Overflow is impossible: DIST_W covers DIM*(2^DATA_W-1).

Optional Feature:
KD_CE_PARALLEL_DIST_EN
- Defined: ACC computes both full distances combinationally in a single cycle, so QUERY latency is T+3 independent of DIM. The dim counter is not instantiated.
- Undefined: serial accumulation as above, latency T+DIM+2.
- Results are identical in both builds.

Test Plan:
- SORT, axis=0, both enables on; left.x=50, parent.x=30, right.x=10 -> new_left=old right, new_parent=old parent, new_right=old left; left_switch=1, parent_switch=0, right_switch=1, stable=0; out_valid at T+2.
- SORT, right_en=0; left.x=20, parent.x=20 (tie) -> outputs equal inputs, stable=1, all switches 0.
- QUERY, axis=0; point=(10,10,10), left=(12,8,10), right=(0,0,0), returned=1 -> change_best=1, new_parent=left, best_dist=4, first_direction=1, other_branch=1 (4>2); out_valid at T+5 (T+3 with KD_CE_PARALLEL_DIST_EN).
- QUERY extreme; point=(0,0,0), left=(255,255,255), right=(1,1,1), returned=0 -> acc_c=765 with no wrap, change_best=0, new_parent=right, best_dist=3, other_branch=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs held constant, in_ready=0, a second in_valid is not accepted; out_ready=1 -> IDLE next cycle, second op then accepted.
- Reset mid-QUERY: rst=0 during 2nd ACC cycle -> immediately out_valid=0, all outputs 0, in_ready=1. After release, a fresh QUERY produces correct results.
